// File: rtl/t03_combat_pkg.sv
// rtl/t03_combat_pkg.sv - shared player/game state encodings for the combat resolver
package t03_combat_pkg;

    typedef enum logic [1:0] {
        PS_INIT     = 2'd0,
        PS_PUNCHING = 2'd1,
        PS_BLOCKING = 2'd2
    } player_state_t;

    typedef enum logic [1:0] {
        GS_WAIT  = 2'd0,
        GS_FIGHT = 2'd1,
        GS_OVER  = 2'd2
    } game_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;

endpackage

// File: rtl/t03_hit_tracker.sv
// rtl/t03_hit_tracker.sv - per-player punch rising-edge detect and invulnerability cooldown
module t03_hit_tracker
    import t03_combat_pkg::*;
#(
    parameter logic [5:0] HIT_COOLDOWN = 6'd30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_clear,
    input  logic [1:0] i_state,
    input  logic       i_resting,
    input  logic       i_hit,
    output logic       o_punch_land,
    output logic       o_block_active,
    output logic       o_cd_zero
);

    logic       w_punch_active;
    logic       r_prev_punch;
    logic [5:0] r_cooldown;

    assign w_punch_active = (i_state == PS_PUNCHING) && !i_resting;
    assign o_block_active = (i_state == PS_BLOCKING) && !i_resting;
    assign o_punch_land   = w_punch_active && !r_prev_punch;
    assign o_cd_zero      = (r_cooldown == 6'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_punch <= 1'b0;
            r_cooldown   <= 6'd0;
        end else if (i_tick) begin
            r_prev_punch <= i_clear ? 1'b0 : w_punch_active;
            // A fresh hit reloads the window even while it is still counting down
            if (i_hit)
                r_cooldown <= HIT_COOLDOWN;
            else if (r_cooldown != 6'd0)
                r_cooldown <= r_cooldown - 6'd1;
        end
    end

endmodule

// File: rtl/t03_combat_resolver.sv
// rtl/t03_combat_resolver.sv - two-player hit/block resolution, health and round state machine
module t03_combat_resolver
    import t03_combat_pkg::*;
#(
    parameter logic [3:0] MAX_HEALTH   = 4'd8,
    parameter logic [5:0] HIT_COOLDOWN = 6'd30,
    parameter logic [7:0] OVER_FRAMES  = 8'd180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       finished,
    input  logic       start,
    input  logic [1:0] p1_state,
    input  logic       p1_resting,
    input  logic [1:0] p2_state,
    input  logic       p2_resting,
    output logic [3:0] p1_health,
    output logic [3:0] p2_health,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic       blocked,
    output logic [1:0] game_state,
    output logic [1:0] winner
);

    logic [1:0] r_state;
    logic [1:0] r_winner;
    logic [3:0] r_p1_health;
    logic [3:0] r_p2_health;
    logic       r_p1_hit;
    logic       r_p2_hit;
    logic       r_blocked;
    logic [7:0] r_over_cnt;

    logic       w_fight;
    logic       w_start_go;
    logic       w_p1_land, w_p1_block, w_p1_cd_zero;
    logic       w_p2_land, w_p2_block, w_p2_cd_zero;
    logic       w_p1_dmg, w_p2_dmg, w_blk;
    logic [3:0] w_p1_next, w_p2_next;

    assign w_fight    = (r_state == GS_FIGHT);
    assign w_start_go = (r_state == GS_WAIT) && start;

    // Damage to a player comes from the opponent's landing punch
    assign w_p1_dmg = w_fight && w_p2_land && !w_p1_block && w_p1_cd_zero;
    assign w_p2_dmg = w_fight && w_p1_land && !w_p2_block && w_p2_cd_zero;
    assign w_blk    = w_fight && ((w_p1_land && w_p2_block) || (w_p2_land && w_p1_block));

    assign w_p1_next = (w_p1_dmg && r_p1_health != 4'd0) ? r_p1_health - 4'd1 : r_p1_health;
    assign w_p2_next = (w_p2_dmg && r_p2_health != 4'd0) ? r_p2_health - 4'd1 : r_p2_health;

    t03_hit_tracker #(.HIT_COOLDOWN(HIT_COOLDOWN)) u_p1 (
        .clk            (clk),
        .rst            (rst),
        .i_tick         (finished),
        .i_clear        (w_start_go),
        .i_state        (p1_state),
        .i_resting      (p1_resting),
        .i_hit          (w_p1_dmg),
        .o_punch_land   (w_p1_land),
        .o_block_active (w_p1_block),
        .o_cd_zero      (w_p1_cd_zero)
    );

    t03_hit_tracker #(.HIT_COOLDOWN(HIT_COOLDOWN)) u_p2 (
        .clk            (clk),
        .rst            (rst),
        .i_tick         (finished),
        .i_clear        (w_start_go),
        .i_state        (p2_state),
        .i_resting      (p2_resting),
        .i_hit          (w_p2_dmg),
        .o_punch_land   (w_p2_land),
        .o_block_active (w_p2_block),
        .o_cd_zero      (w_p2_cd_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= GS_WAIT;
            r_winner    <= WIN_NONE;
            r_p1_health <= MAX_HEALTH;
            r_p2_health <= MAX_HEALTH;
            r_p1_hit    <= 1'b0;
            r_p2_hit    <= 1'b0;
            r_blocked   <= 1'b0;
            r_over_cnt  <= 8'd0;
        end else begin
            r_p1_hit  <= 1'b0;
            r_p2_hit  <= 1'b0;
            r_blocked <= 1'b0;
            if (finished) begin
                case (r_state)
                    GS_WAIT: begin
                        r_p1_health <= MAX_HEALTH;
                        r_p2_health <= MAX_HEALTH;
                        r_winner    <= WIN_NONE;
                        r_over_cnt  <= 8'd0;
                        if (start)
                            r_state <= GS_FIGHT;
                    end
                    GS_FIGHT: begin
                        r_p1_hit    <= w_p1_dmg;
                        r_p2_hit    <= w_p2_dmg;
                        r_blocked   <= w_blk;
                        r_p1_health <= w_p1_next;
                        r_p2_health <= w_p2_next;
                        r_over_cnt  <= 8'd0;
                        // Bit 1 flags P1 knocked out, bit 0 flags P2, so both gives a draw
                        if (w_p1_next == 4'd0 || w_p2_next == 4'd0) begin
                            r_state  <= GS_OVER;
                            r_winner <= {w_p1_next == 4'd0, w_p2_next == 4'd0};
                        end
                    end
                    GS_OVER: begin
                        if (r_over_cnt == OVER_FRAMES - 8'd1) begin
                            r_state     <= GS_WAIT;
                            r_p1_health <= MAX_HEALTH;
                            r_p2_health <= MAX_HEALTH;
                            r_winner    <= WIN_NONE;
                            r_over_cnt  <= 8'd0;
                        end else begin
                            r_over_cnt <= r_over_cnt + 8'd1;
                        end
                    end
                    default: r_state <= GS_WAIT;
                endcase
            end
        end
    end

    assign p1_health  = r_p1_health;
    assign p2_health  = r_p2_health;
    assign p1_hit     = r_p1_hit;
    assign p2_hit     = r_p2_hit;
    assign blocked    = r_blocked;
    assign game_state = r_state;
    assign winner     = r_winner;

endmodule
